// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//  Shared definitions for the SPI slave receiver: the default frame length,
//  the receiver state encoding and the levels the SPI pins rest at when no
//  master is driving a frame. These levels also serve as the synchroniser
//  reset values.
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int DATA_W_DEF = 10;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      RECEIVE      = 2'd1,
      WAIT_CS_HIGH = 2'd2
   } state_t;

   localparam logic CS_IDLE  = 1'b1;
   localparam logic CLK_IDLE = 1'b0;
   localparam logic SDI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
//  Multi-flop synchroniser that brings one asynchronous SPI pin into the clk
//  domain. On reset every stage loads RST_VAL, so the output never shows a
//  spurious edge right after reset.
// Ports:
//  clk    in  1  system clock
//  reset  in  1  asynchronous, active-high reset
//  din    in  1  asynchronous pin
//  dout   out 1  synchronised level (last stage)
// ---------------------------------------------------------------------------
module spi_sync
   import spi_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = SDI_IDLE
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ff <= {STAGES{RST_VAL}};
      end else begin
         // NOTE: flops are written with <= so every stage samples the value
         // from before this clock edge, giving a true shift chain.
         ff <= {ff[STAGES-2:0], din};
      end
   end

   assign dout = ff[STAGES-1];

endmodule

// File: rtl/spi_rx_slave.sv
// ---------------------------------------------------------------------------
// spi_rx_slave
//  SPI slave receiver. It samples sdi on rising spi_clk edges while cs is low,
//  MSB first, and presents each complete DATA_W-bit frame on data_out with a
//  one-cycle data_valid strobe. A frame with the wrong bit count, or one where
//  spi_clk stalls for TIMEOUT cycles, is dropped with a one-cycle frame_err.
// Ports:
//  clk         in  1       system clock
//  reset       in  1       asynchronous, active-high reset
//  spi_clk     in  1       SPI clock from the master (idles low)
//  spi_cs      in  1       chip select, active low
//  spi_sdi     in  1       serial data from the master
//  data_out    out DATA_W  last good frame, held until the next good frame
//  data_valid  out 1       pulse: data_out updated this cycle
//  frame_err   out 1       pulse: frame discarded
//  busy        out 1       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module spi_rx_slave
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_clk,
   input  logic              spi_cs,
   input  logic              spi_sdi,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam int TMO_W = $clog2(TIMEOUT);
   localparam int ST_W  = $clog2(SYNC_STAGES + 2);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [ST_W-1:0]  ST_FIRST = ST_W'(SYNC_STAGES);
   localparam logic [ST_W-1:0]  ST_DONE  = ST_W'(SYNC_STAGES + 1);

   logic cs_s, clk_s, sdi_s;
   logic cs_d, clk_d;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_sync_cs (
      .clk(clk), .reset(reset), .din(spi_cs), .dout(cs_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CLK_IDLE)) u_sync_clk (
      .clk(clk), .reset(reset), .din(spi_clk), .dout(clk_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SDI_IDLE)) u_sync_sdi (
      .clk(clk), .reset(reset), .din(spi_sdi), .dout(sdi_s)
   );

   // Cs fall/rise, and spi_clk rise qualified by cs low so that a clock edge
   // coinciding with cs rising is discarded.
   logic cs_fall, cs_rise, clk_rise;
   assign cs_fall  = cs_d & ~cs_s;
   assign cs_rise  = ~cs_d & cs_s;
   assign clk_rise = ~clk_d & clk_s & ~cs_s;

   // Counts clocks since reset release. The cycle in which it equals
   // SYNC_STAGES is the first in which cs_s reflects the pin; a low cs_s then
   // is a frame already in progress, not a genuine falling edge.
   logic [ST_W-1:0] st_cnt;
   logic            sync_first;
   assign sync_first = (st_cnt == ST_FIRST);

   state_t              state, state_next;
   logic [DATA_W-1:0]   shreg, shreg_next;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_next;
   logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_next;
   logic [DATA_W-1:0]   data_out_next;
   logic                valid_next, err_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_d       <= CS_IDLE;
         clk_d      <= CLK_IDLE;
         st_cnt     <= '0;
         state      <= IDLE;
         // NOTE: the shift register is plain flops rather than a memory, so
         // it is reset along with the rest of the state.
         shreg      <= '0;
         bit_cnt    <= '0;
         tmo_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         cs_d       <= cs_s;
         clk_d      <= clk_s;
         if (st_cnt != ST_DONE) st_cnt <= st_cnt + 1'b1;
         state      <= state_next;
         shreg      <= shreg_next;
         bit_cnt    <= bit_cnt_next;
         tmo_cnt    <= tmo_cnt_next;
         data_out   <= data_out_next;
         data_valid <= valid_next;
         frame_err  <= err_next;
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_next    = state;
      shreg_next    = shreg;
      bit_cnt_next  = bit_cnt;
      tmo_cnt_next  = tmo_cnt;
      data_out_next = data_out;
      valid_next    = 1'b0;
      err_next      = 1'b0;

      case (state)
         IDLE: begin
            if (!cs_s && sync_first) begin
               state_next = WAIT_CS_HIGH;
            end else if (cs_fall) begin
               state_next   = RECEIVE;
               shreg_next   = '0;
               bit_cnt_next = '0;
               tmo_cnt_next = '0;
            end
         end

         RECEIVE: begin
            if (cs_rise) begin
               if (bit_cnt == CNT_FULL) begin
                  data_out_next = shreg;
                  valid_next    = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
               state_next = IDLE;
            end else if (clk_rise) begin
               shreg_next   = {shreg[DATA_W-2:0], sdi_s};
               if (bit_cnt != CNT_MAX) bit_cnt_next = bit_cnt + 1'b1;
               tmo_cnt_next = '0;
            end else if (tmo_cnt == TMO_LAST) begin
               err_next   = 1'b1;
               state_next = WAIT_CS_HIGH;
            end else begin
               tmo_cnt_next = tmo_cnt + 1'b1;
            end
         end

         WAIT_CS_HIGH: begin
            if (cs_s) state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule
